gcd_stream: RTL
===============

GCD_STREAM -- requirements
Module: gcd_stream

Interface
REQ-001 Parameter WIDTH, default 36, operand/result width in bits (WIDTH >= 2).
REQ-002 Parameter MODE, default 0, algorithm: 0 = subtractive Euclid, 1 = binary (Stein).
REQ-003 Parameter CNTW, default 16, width of the iteration counter.
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  operand pair a/b is presented.
REQ-007 in_ready  output  1  block can accept an operand pair.
REQ-008 a  input  WIDTH  first operand, unsigned.
REQ-009 b  input  WIDTH  second operand, unsigned.
REQ-010 out_valid  output  1  res/zero/iters are valid.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 res  output  WIDTH  gcd(a,b).
REQ-013 zero  output  1  both operands were zero (res = 0).
REQ-014 iters  output  CNTW  count of CALC cycles spent, saturating.

Function
REQ-015 FSM states IDLE, CALC, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-016 Accept = in_valid && in_ready at a rising edge; a/b are sampled only on accept and ignored otherwise.
REQ-017 On accept with a == 0 or b == 0: go directly to DONE, res = a | b, zero = (a == 0 && b == 0), iters = 0.
REQ-018 On accept with both nonzero: x = a, y = b, shift count k = 0, iters = 0, go to CALC.
REQ-019 In CALC, if x == y: go to DONE, res = x (MODE 0) or x << k (MODE 1), zero = 0; no iters increment on this cycle.
REQ-020 In CALC with MODE 0 and x != y: the larger of x, y is replaced by the larger minus the smaller, one step per cycle.
REQ-021 In CALC with MODE 1 and x != y, first matching rule per cycle: both even -> x >>= 1, y >>= 1, k++; x even -> x >>= 1; y even -> y >>= 1; x > y -> x = x - y; else y = y - x.
REQ-022 k width = clog2(WIDTH+1); k never exceeds WIDTH-1 for nonzero operands.
REQ-023 Every CALC cycle with x != y increments iters by 1, saturating at 2^CNTW - 1 (no wrap).
REQ-024 All arithmetic is unsigned WIDTH-bit; subtraction is only applied larger-minus-smaller, so it never underflows.
REQ-025 In DONE, res/zero/iters are held stable until out_valid && out_ready; on that edge go to IDLE.
REQ-026 Accepting a new pair in the same cycle as a result is consumed is not supported; in_ready is 0 throughout DONE.
REQ-027 out_ready asserted outside DONE has no effect; in_valid outside IDLE has no effect and the pending pair is not lost (source must hold it).
REQ-028 Latency from accept to out_valid = 1 + (number of non-equal CALC steps) + 1 edges for nonzero operands, and 1 edge for a zero operand.

Reset
REQ-029 Reset asserted asynchronously forces state IDLE, x = y = 0, k = 0, res = 0, zero = 0, iters = 0, out_valid = 0, in_ready = 1 on deassertion.
REQ-030 Reset mid-CALC or mid-DONE discards the operation; no out_valid follows for it.
REQ-031 Reset deassertion is synchronous to clk from the user's side; the first accept is possible on the first rising edge after deassertion.

Verification
REQ-032 MODE 0, accept a = 12, b = 18 -> out_valid rises after the 3rd edge following accept; res = 6, zero = 0, iters = 2.
REQ-033 MODE 1, accept a = 12, b = 18 -> out_valid rises after the 5th edge following accept; res = 6, iters = 4.
REQ-034 Either MODE, accept a = 0, b = 7 -> out_valid after 1 edge, res = 7, zero = 0; accept a = 0, b = 0 -> res = 0, zero = 1.
REQ-035 MODE 0, WIDTH = 36, a = 2^36-1, b = 1, CNTW = 16 -> iters saturates at 65535, stays there, res = 1 eventually.
REQ-036 Hold out_ready = 0 for 10 cycles in DONE -> res/iters stable, in_ready = 0; raise out_ready -> IDLE next edge, in_ready = 1.
REQ-037 Assert reset during CALC for a = 35, b = 21 -> outputs take reset values immediately (asynchronously), no out_valid follows; a new pair then completes normally.

Source files
------------

// File: rtl/gcd_stream.sv
// gcd_stream: streaming GCD engine with a valid/ready operand port and a
// valid/ready result port. One operand pair is in flight at a time; the
// algorithm (subtractive Euclid or binary Stein) is chosen by MODE.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. The producer holds its payload stable while valid is high and
// ready is low; ready never depends combinationally on valid. in_ready is
// high only in IDLE, out_valid only in DONE, so a pair can never be accepted
// on the same edge a result is consumed.
module gcd_stream #(
  parameter int WIDTH = 36,
  parameter int MODE  = 0,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             zero,
  output logic [CNTW-1:0]  iters
);

  localparam int KW = $clog2(WIDTH + 1);
  localparam logic [CNTW-1:0] ITERS_MAX = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // state_q is the FSM state checkers bind to
  state_t           state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic [CNTW-1:0]  iters_q, iters_d;

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      k_q     <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      iters_q <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      k_q     <= k_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      iters_q <= iters_d;
    end
  end

  // Next-state and datapath: one reduction step per CALC cycle
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    k_d     = k_q;
    res_d   = res_q;
    zero_d  = zero_q;
    iters_d = iters_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          iters_d = '0;
          if ((a == '0) || (b == '0)) begin
            // gcd(n, 0) = n, so the nonzero operand (or 0) is the answer
            res_d   = a | b;
            zero_d  = (a == '0) && (b == '0);
            state_d = DONE;
          end else begin
            x_d     = a;
            y_d     = b;
            k_d     = '0;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (x_q == y_q) begin
          // Stein pulled common factors of two out into k; put them back
          res_d   = (MODE == 1) ? (x_q << k_q) : x_q;
          zero_d  = 1'b0;
          state_d = DONE;
        end else begin
          if (iters_q != ITERS_MAX) iters_d = iters_q + 1'b1;
          if (MODE == 1) begin
            if (!x_q[0] && !y_q[0]) begin
              x_d = x_q >> 1;
              y_d = y_q >> 1;
              k_d = k_q + 1'b1;
            end else if (!x_q[0]) begin
              x_d = x_q >> 1;
            end else if (!y_q[0]) begin
              y_d = y_q >> 1;
            end else if (x_q > y_q) begin
              x_d = x_q - y_q;
            end else begin
              y_d = y_q - x_q;
            end
          end else begin
            // always larger minus smaller, so no underflow
            if (x_q > y_q) x_d = x_q - y_q;
            else           y_d = y_q - x_q;
          end
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign res       = res_q;
  assign zero      = zero_q;
  assign iters     = iters_q;

endmodule
